// File: rtl/imm_pkg.sv
// Shared encodings for the immediate decode stage: immediate type codes,
// RV opcodes and funct3 values that steer format selection, skid states.
package imm_pkg;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_C    = 3'd5;
  localparam logic [2:0] IMM_SH   = 3'd6;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SRX  = 3'b101;
  localparam logic [2:0] F3_PRIV = 3'b000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: picks the RV format from opcode/funct3
// and builds the extended immediate plus an illegal-encoding flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [31:0] imm32;
  logic        zext;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

  always_comb begin
    imm32    = '0;
    zext     = 1'b0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        imm32    = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_MISC_MEM: begin
        imm_type = IMM_I;
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          imm_type = IMM_SH;
          zext     = 1'b1;
          // RV64 shifts use a 6-bit shamt; on RV32 a set bit 25 is out of range.
          if (XLEN == 64) begin
            imm32 = {26'b0, instr[25:20]};
          end else begin
            imm32   = {27'b0, instr[24:20]};
            illegal = instr[25];
          end
        end else begin
          imm_type = IMM_I;
          imm32    = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_SYSTEM: begin
        if (funct3 != F3_PRIV) begin
          imm_type = IMM_C;
          zext     = 1'b1;
          imm32    = {27'b0, instr[19:15]};
        end else begin
          imm_type = IMM_I;
          imm32    = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_OP: begin
        imm_type = IMM_NONE;
      end
      OPC_OP_IMM_32: begin
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          imm_type = IMM_SH;
          zext     = 1'b1;
          imm32    = {27'b0, instr[24:20]};
          illegal  = instr[25];
        end else begin
          imm_type = IMM_I;
          imm32    = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_OP_32: begin
        illegal = (XLEN != 64);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = zext ? XLEN'(imm32) : XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage between fetch and execute: immediate, branch/jump
// target and illegal flag, with an optional 2-entry skid buffer.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o,
  output logic [1:0]      dbg_state_o
);

  // Entry layout: {target, imm, type, illegal}.
  localparam int EW = 2 * XLEN + 4;
  localparam logic [EW-1:0] ENT_RESET = {{(2 * XLEN){1'b0}}, IMM_NONE, 1'b0};

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;
  logic [EW-1:0]   dec_ent;

  skid_state_e     state_q;
  logic            out_valid_q;
  logic            ready_q;
  logic [EW-1:0]   head_q;
  logic [EW-1:0]   skid_q;
  logic            accept;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr    (instruction_i),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_ill)
  );

  assign dec_ent = {pc_i + dec_imm, dec_imm, dec_type, dec_ill};

  // Handshake: an input transfer happens on a cycle with in_valid_i & in_ready_o,
  // an output transfer on out_valid_o & out_ready_i; neither side may make
  // valid depend on ready, and flush_i overrides both transfers that cycle.
  assign accept = in_valid_i & in_ready_o;
  assign pop    = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      head_q      <= ENT_RESET;
      skid_q      <= ENT_RESET;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_q      <= dec_ent;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            skid_q  <= dec_ent;
            state_q <= ST_TWO;
            ready_q <= 1'b0;
          end else if (accept) begin
            head_q <= dec_ent;
          end else if (pop) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= ST_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  // Without the skid entry, ready is the classic pass-through form.
  assign in_ready_o  = SKID_EN ? ready_q : (!out_valid_q || out_ready_i);
  assign out_valid_o = out_valid_q;
  assign {target_o, imm_o, imm_type_o, illegal_o} = head_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus and
// are checked each cycle against a queue-based reference of the stage.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
    logic [63:0] tgt;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] instruction_i;
  logic [63:0] pc_i;
  logic        out_ready_i;

  logic        r32, v32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  ty32;
  logic [1:0]  st32;
  logic        r64, v64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  ty64;
  logic [1:0]  st64;

  ent_t exp32_q[$];
  ent_t exp64_q[$];
  ent_t last32, last64;
  ent_t reset_ent;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  imm_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(r32),
    .instruction_i(instruction_i), .pc_i(pc_i[31:0]),
    .out_valid_o(v32), .out_ready_i(out_ready_i),
    .imm_o(imm32), .imm_type_o(ty32), .target_o(tgt32),
    .illegal_o(ill32), .dbg_state_o(st32)
  );

  imm_decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(r64),
    .instruction_i(instruction_i), .pc_i(pc_i),
    .out_valid_o(v64), .out_ready_i(out_ready_i),
    .imm_o(imm64), .imm_type_o(ty64), .target_o(tgt64),
    .illegal_o(ill64), .dbg_state_o(st64)
  );

  function automatic longint sx(input longint val, input int bits);
    return (val <<< (64 - bits)) >>> (64 - bits);
  endfunction

  // Reference decode from field arithmetic: weight each instruction field by
  // its place value in the offset, then sign-extend from the offset's MSB.
  function automatic ent_t ref_dec(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    ent_t   e;
    longint v;
    int     op, f3;
    bit     sh;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    sh = (f3 == 1) || (f3 == 5);
    v = 0;
    e.ty = 3'd7;
    e.ill = 1'b0;
    case (op)
      'h37, 'h17: begin e.ty = 3'd3; v = sx(longint'(ins[31:12]) * 4096, 32); end
      'h6F: begin
        e.ty = 3'd4;
        v = sx(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * (1 << 12)
               + longint'(ins[20]) * (1 << 11) + longint'(ins[30:21]) * 2, 21);
      end
      'h67, 'h03, 'h0F: begin e.ty = 3'd0; v = sx(longint'(ins[31:20]), 12); end
      'h63: begin
        e.ty = 3'd2;
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
               + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      'h23: begin e.ty = 3'd1; v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); end
      'h13: begin
        if (sh) begin
          e.ty = 3'd6;
          if (xlen == 64) v = longint'(ins[25:20]);
          else begin v = longint'(ins[24:20]); e.ill = ins[25]; end
        end else begin
          e.ty = 3'd0; v = sx(longint'(ins[31:20]), 12);
        end
      end
      'h73: begin
        if (f3 != 0) begin e.ty = 3'd5; v = longint'(ins[19:15]); end
        else begin e.ty = 3'd0; v = sx(longint'(ins[31:20]), 12); end
      end
      'h33: e.ty = 3'd7;
      'h1B: begin
        if (xlen != 64) e.ill = 1'b1;
        else if (sh) begin e.ty = 3'd6; v = longint'(ins[24:20]); e.ill = ins[25]; end
        else begin e.ty = 3'd0; v = sx(longint'(ins[31:20]), 12); end
      end
      'h3B: e.ill = (xlen != 64);
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(v);
    e.tgt = pc + 64'(v);
    if (xlen == 32) begin
      e.imm = e.imm & 64'hFFFF_FFFF;
      e.tgt = e.tgt & 64'hFFFF_FFFF;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int   n;
    ent_t e;
    n = exp32_q.size();
    chk("valid32", 64'(v32), 64'(n > 0));
    chk("ready32", 64'(r32), 64'(n < 2));
    chk("state32", 64'(st32), 64'(n));
    e = (n > 0) ? exp32_q[0] : last32;
    last32 = e;
    chk("imm32", 64'(imm32), e.imm);
    chk("type32", 64'(ty32), 64'(e.ty));
    chk("tgt32", 64'(tgt32), e.tgt);
    chk("ill32", 64'(ill32), 64'(e.ill));
    n = exp64_q.size();
    chk("valid64", 64'(v64), 64'(n > 0));
    chk("ready64", 64'(r64), 64'(n < 2));
    chk("state64", 64'(st64), 64'(n));
    e = (n > 0) ? exp64_q[0] : last64;
    last64 = e;
    chk("imm64", imm64, e.imm);
    chk("type64", 64'(ty64), 64'(e.ty));
    chk("tgt64", tgt64, e.tgt);
    chk("ill64", 64'(ill64), 64'(e.ill));
  endtask

  // One clock of stimulus; the model is a FIFO of depth two cleared by flush.
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                      input bit rdy, input bit fl);
    bit acc, pop;
    in_valid_i    = v;
    instruction_i = ins;
    pc_i          = pc;
    out_ready_i   = rdy;
    flush_i       = fl;
    if (fl) begin
      exp32_q.delete();
      exp64_q.delete();
    end else begin
      acc = v && (exp32_q.size() < 2);
      pop = rdy && (exp32_q.size() > 0);
      if (pop) begin
        void'(exp32_q.pop_front());
        void'(exp64_q.pop_front());
      end
      if (acc) begin
        exp32_q.push_back(ref_dec(ins, pc, 32));
        exp64_q.push_back(ref_dec(ins, pc, 64));
      end
    end
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  logic [6:0]  opc_tab [0:14];
  logic [31:0] r;

  initial begin
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h0F, 7'h63, 7'h23,
                7'h13, 7'h73, 7'h33, 7'h1B, 7'h3B, 7'h57, 7'h00};
    reset_ent     = '{imm: 64'd0, ty: 3'd7, ill: 1'b0, tgt: 64'd0};
    last32        = reset_ent;
    last64        = reset_ent;
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    in_valid_i    = 1'b0;
    instruction_i = '0;
    pc_i          = '0;
    out_ready_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    rst_ni = 1'b1;
    check_all();

    // Directed decode cases.
    step(1, 32'hFFF0_0093, 64'h0, 1, 0);
    chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("addi_type32", 64'(ty32), 64'd0);
    step(1, 32'hFE00_0EE3, 64'h100, 1, 0);
    chk("beq_imm32", 64'(imm32), 64'hFFFF_FFFC);
    chk("beq_tgt32", 64'(tgt32), 64'hFC);
    step(1, 32'h0200_9093, 64'h0, 1, 0);
    chk("slli_ill32", 64'(ill32), 64'd1);
    chk("slli_imm64", imm64, 64'd32);
    chk("slli_type64", 64'(ty64), 64'd6);
    chk("slli_ill64", 64'(ill64), 64'd0);
    step(1, 32'h8000_00B7, 64'h0, 1, 0);
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    step(1, 32'h300F_D073, 64'h0, 1, 0);
    chk("csr_imm64", imm64, 64'h1F);
    chk("csr_type64", 64'(ty64), 64'd5);
    step(0, 32'h0, 64'h0, 1, 0);

    // Backpressure: A, B accepted, C held off, then drained in order.
    step(1, 32'h0010_0093, 64'h10, 0, 0);
    step(1, 32'h0020_0113, 64'h14, 0, 0);
    step(1, 32'h0030_0193, 64'h18, 0, 0);
    chk("bp_ready", 64'(r32), 64'd0);
    step(1, 32'h0030_0193, 64'h18, 1, 0);
    step(1, 32'h0030_0193, 64'h18, 1, 0);
    step(0, 32'h0, 64'h0, 1, 0);
    step(0, 32'h0, 64'h0, 1, 0);

    // Flush while full, with an offer on the same cycle.
    step(1, 32'h0040_0213, 64'h20, 0, 0);
    step(1, 32'h0050_0293, 64'h24, 0, 0);
    step(1, 32'h0060_0313, 64'h28, 0, 1);
    chk("flush_valid", 64'(v32), 64'd0);
    chk("flush_ready", 64'(r64), 64'd1);
    step(0, 32'h0, 64'h0, 1, 0);

    // Asynchronous reset in the middle of a stall.
    step(1, 32'h0070_0393, 64'h30, 0, 0);
    step(1, 32'h0080_0413, 64'h34, 0, 0);
    rst_ni = 1'b0;
    #2;
    exp32_q.delete();
    exp64_q.delete();
    last32 = reset_ent;
    last64 = reset_ent;
    check_all();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_all();

    // Randomized traffic across all opcode groups.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] pc;
      logic [31:0] ins;
      r   = $urandom();
      ins = {r[31:7], opc_tab[$urandom_range(0, 14)]};
      pc  = {$urandom(), $urandom()};
      step($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    end
    step(0, 32'h0, 64'h0, 1, 0);
    step(0, 32'h0, 64'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
